// File: rtl/core_pkg.sv
// core_pkg: widths, idle instruction word and fetch FSM states shared by the fetch unit
package core_pkg;
  localparam int ADDR_W = 16;
  localparam int IR_W = 16;
  localparam logic [IR_W-1:0] NOP_IR = 16'h0000;
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} fetch_state_e;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: DEPTH-entry synchronous FIFO of {ir, pc}; flush wins over push
module fetch_buffer #(
  parameter int W = 32,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clock_50,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [AW:0]   count,
  output logic [W-1:0]  head
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] count_q, count_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = din;
    wr_d = flush ? '0 : wr_q + AW'(push);
    rd_d = flush ? '0 : rd_q + AW'(pop);
    count_d = flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clock_50) begin
    mem_q <= mem_d;
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end
  assign count = count_q;
  assign head = mem_q[rd_q];
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, synchronous imem reads and a credit-limited fetch buffer feeding the core's IR
module instr_fetch_unit #(
  parameter int ADDR_W = core_pkg::ADDR_W,
  parameter int IR_W = core_pkg::IR_W,
  parameter int DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [IR_W-1:0] NOP_IR = core_pkg::NOP_IR
) (
  input  logic              clock_50,
  input  logic              rst_n,
  output logic              imem_rd,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [IR_W-1:0]   imem_data,
  output logic [IR_W-1:0]   ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt
);
  import core_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;
  fetch_state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, rd_pc_q, rd_pc_d;
  logic inflight_q, inflight_d, pop, issue;
  logic [CW-1:0] count;
  logic [IR_W+ADDR_W-1:0] head;
  fetch_buffer #(.W(IR_W+ADDR_W), .DEPTH(DEPTH)) u_buf (
    .clock_50(clock_50),
    .rst_n(rst_n),
    .push(inflight_q),
    .pop(pop),
    .flush(redirect),
    .din({imem_data, rd_pc_q}),
    .count(count),
    .head(head)
  );
  assign ir_valid = count != '0;
  assign ir = ir_valid ? head[IR_W+ADDR_W-1 -: IR_W] : NOP_IR;
  assign ir_pc = ir_valid ? head[ADDR_W-1:0] : '0;
  assign pop = ir_valid && ir_ready;
  assign imem_rd = issue;
  assign imem_addr = pc_q;
  // a read in flight already owns a buffer slot, so the buffer can never overflow
  always_comb begin
    issue = state_q == S_RUN && !redirect && (int'(count) + int'(inflight_q) - int'(pop)) < DEPTH;
    state_d = halt ? S_HALT : S_RUN;
    pc_d = redirect ? redirect_pc : pc_q + ADDR_W'(issue);
    inflight_d = issue;
    rd_pc_d = pc_q;
  end
  always_ff @(posedge clock_50) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      rd_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      inflight_q <= inflight_d;
      rd_pc_q <= rd_pc_d;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: queue-based reference model checked every cycle plus directed literal checks
module tb_instr_fetch_unit;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, rst2_n, ir_ready, redirect, halt;
  logic [15:0] redirect_pc;
  logic imem_rd, ir_valid, imem_rd2, ir_valid2;
  logic [15:0] imem_addr, imem_data, ir, ir_pc;
  logic [15:0] imem_addr2, imem_data2, ir2, ir_pc2;
  int n_cmp = 0, n_err = 0;

  instr_fetch_unit dut (
    .clock_50(clk), .rst_n(rst_n), .imem_rd(imem_rd), .imem_addr(imem_addr),
    .imem_data(imem_data), .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid),
    .ir_ready(ir_ready), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt)
  );
  instr_fetch_unit #(.RESET_PC(16'hFFFE)) dut2 (
    .clock_50(clk), .rst_n(rst2_n), .imem_rd(imem_rd2), .imem_addr(imem_addr2),
    .imem_data(imem_data2), .ir(ir2), .ir_pc(ir_pc2), .ir_valid(ir_valid2),
    .ir_ready(1'b1), .redirect(1'b0), .redirect_pc(16'h0000), .halt(1'b0)
  );

  function automatic logic [15:0] rom(logic [15:0] a);
    return 16'h1000 + a;
  endfunction

  always @(posedge clk) begin
    imem_data <= imem_rd ? rom(imem_addr) : 16'hBAD0;
    imem_data2 <= imem_rd2 ? rom(imem_addr2) : 16'hBAD0;
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  logic m_live = 1'b0;
  int m_state;
  logic m_fl;
  logic [15:0] m_pc, m_fl_addr;
  logic [15:0] m_buf[$];
  logic s_rd, s_valid;
  logic [15:0] s_addr, s_ir, s_pc;
  logic [15:0] q2[$];
  logic [15:0] q2i[$];

  task automatic model_cycle();
    logic ev, pop, er;
    logic [15:0] eir, epc;
    ev = 1'b0; pop = 1'b0; er = 1'b0;
    s_rd = imem_rd; s_addr = imem_addr; s_valid = ir_valid; s_ir = ir; s_pc = ir_pc;
    if (ir_valid2 === 1'b1 && q2.size() < 4) begin
      q2.push_back(ir_pc2);
      q2i.push_back(ir2);
    end
    if (m_live) begin
      ev = m_buf.size() > 0;
      eir = ev ? rom(m_buf[0]) : 16'h0000;
      epc = ev ? m_buf[0] : 16'h0000;
      pop = ev && ir_ready;
      er = m_state == 1 && !redirect && (m_buf.size() + int'(m_fl) - int'(pop)) < DEPTH;
      chk("ir_valid", ir_valid, ev);
      chk("ir", ir, eir);
      chk("ir_pc", ir_pc, epc);
      chk("imem_rd", imem_rd, er);
      if (er) chk("imem_addr", imem_addr, m_pc);
    end
    if (!rst_n) begin
      m_live = 1'b1; m_state = 0; m_pc = 16'h0000; m_fl = 1'b0; m_fl_addr = 16'h0000;
      m_buf.delete();
    end else if (m_live) begin
      if (pop) void'(m_buf.pop_front());
      if (redirect) m_buf.delete();
      else if (m_fl) m_buf.push_back(m_fl_addr);
      m_fl = er;
      m_fl_addr = m_pc;
      m_pc = redirect ? redirect_pc : m_pc + 16'(er);
      m_state = halt ? 2 : 1;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] e5[4];
    logic found;
    e5 = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    rst_n = 1'b0; rst2_n = 1'b0; ir_ready = 1'b1; redirect = 1'b0; halt = 1'b0; redirect_pc = 16'h0000;
    @(posedge clk); #1;
    cyc();
    cyc();
    chk("rst_valid", s_valid, 1'b0);
    chk("rst_rd", s_rd, 1'b0);
    chk("rst_ir", s_ir, 16'h0000);
    chk("rst_pc", s_pc, 16'h0000);
    rst_n = 1'b1; rst2_n = 1'b1;
    cyc();
    chk("t1_boot_rd", s_rd, 1'b0);
    cyc();
    chk("t1_first_rd", s_rd, 1'b1);
    chk("t1_first_addr", s_addr, 16'h0000);
    cyc();
    chk("t1_valid_early", s_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t1_valid", s_valid, 1'b1);
      chk("t1_ir", s_ir, 16'h1000 + 16'(i));
      chk("t1_pc", s_pc, 16'(i));
    end
    ir_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t2_hold_ir", s_ir, 16'h1003);
      chk("t2_hold_pc", s_pc, 16'h0003);
    end
    ir_ready = 1'b1;
    cyc();
    chk("t2_resume0", s_pc, 16'h0003);
    cyc();
    chk("t2_resume1", s_pc, 16'h0004);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_buf.size() > 0 && m_buf[0] == 16'h0005) found = 1'b1;
      else cyc();
    end
    chk("t3_reach_pc5", found, 1'b1);
    redirect = 1'b1; redirect_pc = 16'h0040;
    cyc();
    chk("t3_pop_pc5", s_pc, 16'h0005);
    chk("t3_pop_valid", s_valid, 1'b1);
    redirect = 1'b0;
    cyc();
    chk("t3_bubble1", s_valid, 1'b0);
    cyc();
    chk("t3_bubble2", s_valid, 1'b0);
    cyc();
    chk("t3_target_ir", s_ir, 16'h1040);
    chk("t3_target_pc", s_pc, 16'h0040);
    cyc();
    chk("t3_next_pc", s_pc, 16'h0041);
    halt = 1'b1;
    cyc();
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t4_halt_rd", s_rd, 1'b0);
    end
    chk("t4_drained", s_valid, 1'b0);
    halt = 1'b0;
    cyc();
    chk("t4_leave_rd", s_rd, 1'b0);
    cyc();
    chk("t4_resume_rd", s_rd, 1'b1);
    chk("t4_resume_addr", s_addr, 16'h0045);
    halt = 1'b1; redirect = 1'b1; redirect_pc = 16'h0100;
    cyc();
    chk("t4r_no_rd", s_rd, 1'b0);
    redirect = 1'b0;
    cyc();
    cyc();
    halt = 1'b0;
    cyc();
    cyc();
    chk("t4r_rd", s_rd, 1'b1);
    chk("t4r_addr", s_addr, 16'h0100);
    cyc();
    cyc();
    chk("t4r_ir", s_ir, 16'h1100);
    chk("t4r_pc", s_pc, 16'h0100);
    rst_n = 1'b0;
    cyc();
    chk("t6_rd_at_reset", s_rd, 1'b1);
    rst_n = 1'b1;
    cyc();
    chk("t6_valid_after", s_valid, 1'b0);
    chk("t6_boot_rd", s_rd, 1'b0);
    cyc();
    chk("t6_refetch_addr", s_addr, 16'h0000);
    cyc();
    chk("t6_no_stale", s_valid, 1'b0);
    cyc();
    chk("t6_ir", s_ir, 16'h1000);
    chk("t6_pc", s_pc, 16'h0000);
    for (int i = 0; i < 4; i++) cyc();
    chk("t5_count", q2.size(), 4);
    if (q2.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t5_pc", q2[i], e5[i]);
      chk("t5_ir_wrap", q2i[2], 16'h1000);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
